// File: rtl/syshdwtp_button_debounce_pio.sv
// syshdwtp_button_debounce_pio: Avalon-MM input PIO with per-channel synchroniser, debounce and edge capture.
module syshdwtp_button_debounce_pio #(
  parameter int WIDTH = 8,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_TOP = CW'(DEBOUNCE_CYCLES - 1);
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
  logic [WIDTH-1:0][CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] s, upd, wd, q_q, q_d, rise_en_q, rise_en_d, fall_en_q, fall_en_d;
  logic [WIDTH-1:0] mask_q, mask_d, cap_q, cap_d;
  logic [31:0] readdata_q, readdata_d;
  logic wr, unused;
  assign s = sync_q[SYNC_STAGES-1];
  assign wd = writedata[WIDTH-1:0];
  assign wr = chipselect & ~write_n;
  assign unused = ^writedata;
  assign irq = |(cap_q & mask_q);
  assign readdata = readdata_q;
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], in_port};
    cnt_d = cnt_q;
    q_d = q_q;
    upd = '0;
    for (int i = 0; i < WIDTH; i++) begin
      upd[i] = (s[i] != q_q[i]) && (cnt_q[i] == CNT_TOP);
      cnt_d[i] = (s[i] == q_q[i] || upd[i]) ? '0 : cnt_q[i] + CW'(1);
      q_d[i] = upd[i] ? s[i] : q_q[i];
    end
    rise_en_d = (wr && address == 3'd1) ? wd : rise_en_q;
    mask_d = (wr && address == 3'd2) ? wd : mask_q;
    fall_en_d = (wr && address == 3'd4) ? wd : fall_en_q;
    // new events are OR-ed in after the clear so a coincident event survives
    cap_d = (cap_q & ~((wr && address == 3'd3) ? wd : '0)) | (upd & s & rise_en_q) | (upd & ~s & fall_en_q);
    readdata_d = address == 3'd0 ? 32'(q_q) :
                 address == 3'd1 ? 32'(rise_en_q) :
                 address == 3'd2 ? 32'(mask_q) :
                 address == 3'd3 ? 32'(cap_q) :
                 address == 3'd4 ? 32'(fall_en_q) :
                 address == 3'd5 ? 32'(s) : '0;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      cnt_q <= '0;
      q_q <= '0;
      rise_en_q <= '1;
      fall_en_q <= '0;
      mask_q <= '0;
      cap_q <= '0;
      readdata_q <= '0;
    end else begin
      sync_q <= sync_d;
      cnt_q <= cnt_d;
      q_q <= q_d;
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      mask_q <= mask_d;
      cap_q <= cap_d;
      readdata_q <= readdata_d;
    end
  end
endmodule

// File: tb/tb_syshdwtp_button_debounce_pio.sv
// tb_syshdwtp_button_debounce_pio: directed checks of debounce timing, edge capture, W1C and register map.
module tb_syshdwtp_button_debounce_pio;
  logic clk = 1'b0, reset_n = 1'b0, chipselect = 1'b0, write_n = 1'b1, irq;
  logic [2:0] address = '0;
  logic [31:0] writedata = '0, readdata, v;
  logic [7:0] in_port = '0;
  int n_chk = 0, n_fail = 0;
  syshdwtp_button_debounce_pio #(.WIDTH(8), .DEBOUNCE_CYCLES(4), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in_port), .readdata(readdata), .irq(irq)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address = a;
    writedata = d;
    chipselect = 1'b1;
    write_n = 1'b0;
    tick(1);
    chipselect = 1'b0;
    write_n = 1'b1;
  endtask
  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    address = a;
    tick(1);
    d = readdata;
  endtask
  initial begin
    tick(3);
    reset_n = 1'b1;
    tick(2);
    check("init_readdata", readdata, 32'h0);
    check("init_irq", {31'b0, irq}, 32'h0);
    // clean press on bit 0, edge 0 is the edge just passed
    wr(3'd2, 32'h01);
    address = 3'd5;
    in_port = 8'h01;
    tick(2);
    check("raw_early", readdata, 32'h00);
    tick(1);
    check("raw_after_sync", readdata, 32'h01);
    tick(2);
    check("irq_edge5", {31'b0, irq}, 32'h0);
    tick(1);
    check("irq_edge6", {31'b0, irq}, 32'h1);
    rd(3'd0, v); check("press_data", v, 32'h01);
    rd(3'd3, v); check("press_cap", v, 32'h01);
    wr(3'd3, 32'h01);
    check("press_clr_irq", {31'b0, irq}, 32'h0);
    // glitch of 3 cycles on bit 3 is rejected
    wr(3'd2, 32'h09);
    in_port = 8'h09;
    tick(3);
    in_port = 8'h01;
    tick(10);
    check("glitch_irq", {31'b0, irq}, 32'h0);
    rd(3'd0, v); check("glitch_data", v, 32'h01);
    rd(3'd3, v); check("glitch_cap", v, 32'h00);
    // 4-cycle pulse passes
    in_port = 8'h09;
    tick(4);
    in_port = 8'h01;
    tick(2);
    rd(3'd0, v); check("pulse_data", v, 32'h09);
    tick(10);
    rd(3'd3, v); check("pulse_cap", v, 32'h08);
    check("pulse_irq", {31'b0, irq}, 32'h1);
    rd(3'd0, v); check("pulse_data_after", v, 32'h01);
    wr(3'd3, 32'h08);
    // falling-edge only on bit 7
    wr(3'd4, 32'h80);
    wr(3'd1, 32'h00);
    wr(3'd2, 32'h80);
    in_port = 8'h81;
    tick(10);
    rd(3'd3, v); check("fall_press_cap", v, 32'h00);
    check("fall_press_irq", {31'b0, irq}, 32'h0);
    rd(3'd0, v); check("fall_press_data", v, 32'h81);
    in_port = 8'h01;
    tick(10);
    rd(3'd3, v); check("fall_release_cap", v, 32'h80);
    check("fall_release_irq", {31'b0, irq}, 32'h1);
    rd(3'd0, v); check("fall_release_data", v, 32'h01);
    wr(3'd3, 32'hFF);
    wr(3'd1, 32'hFF);
    wr(3'd4, 32'h00);
    // W1C
    in_port = 8'h00;
    tick(10);
    in_port = 8'h05;
    tick(10);
    rd(3'd3, v); check("w1c_pre", v, 32'h05);
    wr(3'd2, 32'h01);
    check("w1c_irq_pre", {31'b0, irq}, 32'h1);
    wr(3'd3, 32'h01);
    rd(3'd3, v); check("w1c_post", v, 32'h04);
    check("w1c_irq_post", {31'b0, irq}, 32'h0);
    wr(3'd2, 32'h04);
    check("w1c_irq_mask4", {31'b0, irq}, 32'h1);
    // clear of bit 2 lands on the same edge as its falling event
    wr(3'd4, 32'h04);
    in_port = 8'h01;
    tick(5);
    wr(3'd3, 32'h04);
    rd(3'd3, v); check("w1c_coincident", v, 32'h04);
    wr(3'd3, 32'h04);
    rd(3'd3, v); check("w1c_clear_alone", v, 32'h00);
    // writes to read-only/reserved addresses
    wr(3'd0, 32'hFF);
    wr(3'd5, 32'hFF);
    wr(3'd6, 32'hFF);
    rd(3'd0, v); check("ro_data", v, 32'h01);
    rd(3'd5, v); check("ro_raw", v, 32'h01);
    rd(3'd6, v); check("rsv6", v, 32'h00);
    rd(3'd7, v); check("rsv7", v, 32'h00);
    rd(3'd1, v); check("ro_rise_en", v, 32'hFF);
    rd(3'd2, v); check("ro_mask", v, 32'h04);
    rd(3'd3, v); check("ro_cap", v, 32'h00);
    rd(3'd4, v); check("ro_fall_en", v, 32'h04);
    // reset mid-operation with irq high and nonzero readdata
    in_port = 8'h03;
    tick(10);
    wr(3'd2, 32'h02);
    rd(3'd3, v); check("mid_cap", v, 32'h02);
    check("mid_irq", {31'b0, irq}, 32'h1);
    #3 reset_n = 1'b0;
    #1;
    check("rst_readdata", readdata, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    tick(2);
    reset_n = 1'b1;
    rd(3'd0, v); check("rst_data", v, 32'h00);
    rd(3'd1, v); check("rst_rise_en", v, 32'hFF);
    rd(3'd2, v); check("rst_mask", v, 32'h00);
    rd(3'd3, v); check("rst_cap", v, 32'h00);
    rd(3'd4, v); check("rst_fall_en", v, 32'h00);
    tick(3);
    rd(3'd3, v); check("rst_held_rise", v, 32'h03);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
